dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port 256x16 data memory between the processor controller (CPU port) and a second master (DMA/debug loader port). It grants at most one access per clock, drives the memory address/write lines, and returns read data one cycle later with a per-port valid. The CPU has fixed priority, and a wait counter guarantees the DMA port cannot starve. It sits between the controller/datapath and the data memory, replacing the controller's direct drive of D_addr/D_wr.

## Interface
- AW, 8, memory address width
- DW, 16, memory data width
- MAX_WAIT, 3, cycles DMA may be refused while requesting before it is forced to win (range 1..15)

- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- c_req  in  1  CPU access request
- c_we  in  1  CPU write (1) / read (0)
- c_addr  in  AW  CPU address
- c_wdata  in  DW  CPU write data
- c_gnt  out  1  CPU granted this cycle
- c_rvalid  out  1  CPU read data valid on rdata
- d_req, d_we, d_addr, d_wdata  in  1/1/AW/DW  DMA request fields, same meaning
- d_gnt  out  1  DMA granted this cycle
- d_rvalid  out  1  DMA read data valid on rdata
- rdata  out  DW  shared read return, equals D_rdata
- D_addr  out  AW  memory address
- D_wr  out  1  memory write enable
- D_wdata  out  DW  memory write data
- D_rdata  in  DW  memory read data, registered-address RAM (1-cycle latency)
- d_starved  out  1  DMA wait counter at MAX_WAIT (forced grant this cycle)

## Operation
- Handshake: a requester holds req/we/addr/wdata stable until it samples its gnt high at a rising edge. The access completes on that edge. The requester may drop req or present a new request in the next cycle.
- Grant decision is combinational from c_req, d_req, and the registered wait count:
  - only c_req: CPU.
  - only d_req: DMA.
  - both high: CPU, unless wait_cnt == MAX_WAIT, in which case DMA.
  - neither: no grant; D_addr=0, D_wr=0, D_wdata=0.
- c_gnt and d_gnt are never high together. Both are forced 0 while Reset is high.
- Granted port's addr/wdata are muxed to D_addr/D_wdata. D_wr = gnt & we of the granted port.
- wait_cnt (4-bit register):
  - clears to 0 on reset, on any DMA grant, and whenever d_req is low.
  - increments when d_req=1 and d_gnt=0, saturating at MAX_WAIT.
  - d_starved = (wait_cnt == MAX_WAIT).
- Read return FSM, states IDLE / RD_CPU / RD_DMA. A read grant moves it to RD_CPU or RD_DMA; a write grant or no grant moves it to IDLE. Any state can transition to any state every cycle, so back-to-back reads are fully pipelined.
- c_rvalid = (state==RD_CPU), d_rvalid = (state==RD_DMA). rdata passes through D_rdata unregistered.
- Writes produce no rvalid.

## Timing
- Grant latency 0 cycles: gnt is visible in the same cycle the request is presented, if that port wins.
- Write commits at the rising edge ending the grant cycle.
- Read data valid exactly 1 cycle after the grant cycle, for exactly 1 cycle.
- Peak throughput is 1 access per clock, with any read/write mix.
- Reset (async, mid-operation): state returns to IDLE, wait_cnt goes to 0, and all outputs go to 0 immediately. An in-flight read's rvalid is dropped, and requesters must reissue. The first grant is possible in the first cycle after Reset deasserts.
- Both ports requesting continuously with MAX_WAIT=3 gives the grant pattern C,C,C,D repeating (DMA gets at least 1 of every MAX_WAIT+1 cycles).
- A DMA request dropped before grant clears wait_cnt; the starvation credit is not retained.

## Structure
- Shared package dmem_arb_pkg holds:
  - the read-return state enum (IDLE, RD_CPU, RD_DMA).
  - the port identifier constants PORT_CPU=0, PORT_DMA=1.
  - default AW/DW localparams matching the processor's 8-bit data address and 16-bit word.
- Flat single module. No sub-module is warranted: the mux, counter, and 3-state FSM are each a few lines.

## Test plan
- Reset mid-read: CPU read addr 8'h10 granted, Reset pulsed before the next edge. Required: c_rvalid never asserts, all outputs 0 during reset, and a new CPU read after release returns correctly.
- CPU alone: write 16'hBEEF to 8'h2A, then read 8'h2A on the next cycle. Required: c_gnt high both cycles, D_wr=1 only on the first, c_rvalid=1 with rdata=16'hBEEF one cycle after the read grant.
- DMA alone: back-to-back reads of 8'h00, 8'h01, 8'h02. Required: d_gnt high 3 consecutive cycles, and d_rvalid high the 3 following cycles with the matching data in order.
- Contention: c_req and d_req held high for 8 cycles, MAX_WAIT=3. Required: grants C,C,C,D,C,C,C,D, and d_starved high on cycles 4 and 8.
- Starvation reset: d_req high for 2 contended cycles, dropped for 1 cycle, then reasserted with c_req still high. Required: DMA not granted until 3 further cycles have elapsed (wait_cnt restarted from 0).
- Mixed ports: cycle 1 CPU read of 8'h05 (contents 16'h1234), cycle 2 DMA write of 8'h05 ← 16'h5678 (CPU idle). Required: c_rvalid with 16'h1234 in cycle 2, and a subsequent read returns 16'h5678.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Read-return state, port ids and default bus widths.
package dmem_arb_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 16;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RD_CPU,
    RD_DMA
  } rd_state_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data memory.
// CPU has fixed priority; DMA is force-granted after MAX_WAIT refusals.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_WAIT = 3
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] D_addr,
  output logic          D_wr,
  output logic [DW-1:0] D_wdata,
  input  logic [DW-1:0] D_rdata,
  output logic          d_starved
);

  localparam logic [3:0] LP_MAX = 4'(MAX_WAIT);

  rd_state_e  r_state;
  rd_state_e  w_next;
  logic [3:0] r_wait;
  logic       w_starved;
  logic       w_c_gnt;
  logic       w_d_gnt;
  logic       w_sel;
  logic       w_any;

  assign w_starved = (r_wait == LP_MAX);

  // CPU wins ties unless the DMA has used up its waiting credit
  assign w_c_gnt = ~Reset & c_req
                 & ~(d_req & w_starved);
  assign w_d_gnt = ~Reset & d_req & ~w_c_gnt;
  assign w_any   = w_c_gnt | w_d_gnt;
  assign w_sel   = w_d_gnt ? PORT_DMA : PORT_CPU;

  always_comb begin
    D_addr  = '0;
    D_wr    = 1'b0;
    D_wdata = '0;
    if (w_any) begin
      if (w_sel == PORT_DMA) begin
        D_addr  = d_addr;
        D_wr    = d_we;
        D_wdata = d_wdata;
      end else begin
        D_addr  = c_addr;
        D_wr    = c_we;
        D_wdata = c_wdata;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_wait <= 4'd0;
    end else if (d_req & ~w_d_gnt) begin
      if (r_wait != LP_MAX)
        r_wait <= r_wait + 4'd1;
    end else begin
      r_wait <= 4'd0;
    end
  end

  always_comb begin
    w_next = IDLE;
    unique case (1'b1)
      w_c_gnt & ~c_we: w_next = RD_CPU;
      w_d_gnt & ~d_we: w_next = RD_DMA;
      default:         w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  assign c_gnt     = w_c_gnt;
  assign d_gnt     = w_d_gnt;
  assign c_rvalid  = (r_state == RD_CPU);
  assign d_rvalid  = (r_state == RD_DMA);
  assign d_starved = w_starved;
  assign rdata     = Reset ? '0 : D_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a registered-address RAM model.
// Vector table per cycle plus a hand-written mid-read reset sequence.
module tb_dmem_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        c_req, c_we, d_req, d_we;
  logic [7:0]  c_addr, d_addr, D_addr;
  logic [15:0] c_wdata, d_wdata, D_wdata;
  logic [15:0] rdata, D_rdata;
  logic        c_gnt, d_gnt, c_rvalid, d_rvalid;
  logic        D_wr, d_starved;

  int n_chk = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  dmem_arbiter #(.AW(8), .DW(16), .MAX_WAIT(3)) dut (
    .Clk(Clk), .Reset(Reset),
    .c_req(c_req), .c_we(c_we),
    .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid),
    .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .rdata(rdata), .D_addr(D_addr),
    .D_wr(D_wr), .D_wdata(D_wdata),
    .D_rdata(D_rdata), .d_starved(d_starved)
  );

  logic [15:0] mem [256];
  logic [7:0]  r_ma;

  initial begin
    for (int i = 0; i < 256; i++)
      mem[i] <= 16'h1000 + 16'(i);
    mem[5] <= 16'h1234;
    r_ma   <= 8'h00;
  end

  always @(posedge Clk) begin
    if (D_wr) mem[D_addr] <= D_wdata;
    r_ma <= D_addr;
  end

  assign D_rdata = mem[r_ma];

  typedef struct {
    logic        cr, cw;
    logic [7:0]  ca;
    logic [15:0] cd;
    logic        dr, dw;
    logic [7:0]  da;
    logic [15:0] dd;
    logic        gc, gd, wr;
    logic [7:0]  ad;
    logic [15:0] wd;
    logic        crv, drv;
    logic [15:0] rd;
    logic        st;
  } vec_t;

  localparam int NV = 29;
  vec_t vt [NV];

  function automatic vec_t mk(
    logic cr, logic cw, logic [7:0] ca, logic [15:0] cd,
    logic dr, logic dw, logic [7:0] da, logic [15:0] dd,
    logic gc, logic gd, logic wr,
    logic [7:0] ad, logic [15:0] wd,
    logic crv, logic drv, logic [15:0] rd, logic st);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.gc = gc; v.gd = gd; v.wr = wr;
    v.ad = ad; v.wd = wd;
    v.crv = crv; v.drv = drv; v.rd = rd; v.st = st;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    c_req = v.cr; c_we = v.cw;
    c_addr = v.ca; c_wdata = v.cd;
    d_req = v.dr; d_we = v.dw;
    d_addr = v.da; d_wdata = v.dd;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " c_gnt"}, 32'(c_gnt), 0);
    chk({tag, " d_gnt"}, 32'(d_gnt), 0);
    chk({tag, " D_wr"}, 32'(D_wr), 0);
    chk({tag, " D_addr"}, 32'(D_addr), 0);
    chk({tag, " D_wdata"}, 32'(D_wdata), 0);
    chk({tag, " c_rvalid"}, 32'(c_rvalid), 0);
    chk({tag, " d_rvalid"}, 32'(d_rvalid), 0);
    chk({tag, " rdata"}, 32'(rdata), 0);
    chk({tag, " d_starved"}, 32'(d_starved), 0);
  endtask

  initial begin
    vec_t idle;
    vec_t crd10;
    string s;
    idle  = mk(0,0,8'h00,16'h0, 0,0,8'h00,16'h0,
               0,0,0,8'h00,16'h0, 0,0,16'h0,0);
    crd10 = mk(1,0,8'h10,16'h0, 0,0,8'h00,16'h0,
               0,0,0,8'h00,16'h0, 0,0,16'h0,0);

    // CPU alone: write then read
    vt[0]  = idle;
    vt[1]  = mk(1,1,8'h2A,16'hBEEF, 0,0,8'h00,16'h0,
                1,0,1,8'h2A,16'hBEEF, 0,0,16'h0,0);
    vt[2]  = mk(1,0,8'h2A,16'h0, 0,0,8'h00,16'h0,
                1,0,0,8'h2A,16'h0, 0,0,16'h0,0);
    vt[3]  = mk(0,0,8'h00,16'h0, 0,0,8'h00,16'h0,
                0,0,0,8'h00,16'h0, 1,0,16'hBEEF,0);
    // DMA alone: pipelined reads
    vt[4]  = mk(0,0,8'h00,16'h0, 1,0,8'h00,16'h0,
                0,1,0,8'h00,16'h0, 0,0,16'h0,0);
    vt[5]  = mk(0,0,8'h00,16'h0, 1,0,8'h01,16'h0,
                0,1,0,8'h01,16'h0, 0,1,16'h1000,0);
    vt[6]  = mk(0,0,8'h00,16'h0, 1,0,8'h02,16'h0,
                0,1,0,8'h02,16'h0, 0,1,16'h1001,0);
    vt[7]  = mk(0,0,8'h00,16'h0, 0,0,8'h00,16'h0,
                0,0,0,8'h00,16'h0, 0,1,16'h1002,0);
    // Contention: C,C,C,D,C,C,C,D
    vt[8]  = mk(1,0,8'h10,16'h0, 1,0,8'h20,16'h0,
                1,0,0,8'h10,16'h0, 0,0,16'h0,0);
    vt[9]  = mk(1,0,8'h10,16'h0, 1,0,8'h20,16'h0,
                1,0,0,8'h10,16'h0, 1,0,16'h1010,0);
    vt[10] = mk(1,0,8'h10,16'h0, 1,0,8'h20,16'h0,
                1,0,0,8'h10,16'h0, 1,0,16'h1010,0);
    vt[11] = mk(1,0,8'h10,16'h0, 1,0,8'h20,16'h0,
                0,1,0,8'h20,16'h0, 1,0,16'h1010,1);
    vt[12] = mk(1,0,8'h10,16'h0, 1,0,8'h20,16'h0,
                1,0,0,8'h10,16'h0, 0,1,16'h1020,0);
    vt[13] = mk(1,0,8'h10,16'h0, 1,0,8'h20,16'h0,
                1,0,0,8'h10,16'h0, 1,0,16'h1010,0);
    vt[14] = mk(1,0,8'h10,16'h0, 1,0,8'h20,16'h0,
                1,0,0,8'h10,16'h0, 1,0,16'h1010,0);
    vt[15] = mk(1,0,8'h10,16'h0, 1,0,8'h20,16'h0,
                0,1,0,8'h20,16'h0, 1,0,16'h1010,1);
    vt[16] = mk(0,0,8'h00,16'h0, 0,0,8'h00,16'h0,
                0,0,0,8'h00,16'h0, 0,1,16'h1020,0);
    // Dropped DMA request loses its credit
    vt[17] = mk(1,1,8'h80,16'h7777, 1,0,8'h30,16'h0,
                1,0,1,8'h80,16'h7777, 0,0,16'h0,0);
    vt[18] = vt[17];
    vt[19] = mk(1,1,8'h80,16'h7777, 0,0,8'h30,16'h0,
                1,0,1,8'h80,16'h7777, 0,0,16'h0,0);
    vt[20] = vt[17];
    vt[21] = vt[17];
    vt[22] = vt[17];
    vt[23] = mk(1,1,8'h80,16'h7777, 1,0,8'h30,16'h0,
                0,1,0,8'h30,16'h0, 0,0,16'h0,1);
    vt[24] = mk(0,0,8'h00,16'h0, 0,0,8'h00,16'h0,
                0,0,0,8'h00,16'h0, 0,1,16'h1030,0);
    // Mixed ports on the same address
    vt[25] = mk(1,0,8'h05,16'h0, 0,0,8'h00,16'h0,
                1,0,0,8'h05,16'h0, 0,0,16'h0,0);
    vt[26] = mk(0,0,8'h00,16'h0, 1,1,8'h05,16'h5678,
                0,1,1,8'h05,16'h5678, 1,0,16'h1234,0);
    vt[27] = vt[25];
    vt[28] = mk(0,0,8'h00,16'h0, 0,0,8'h00,16'h0,
                0,0,0,8'h00,16'h0, 1,0,16'h5678,0);

    Reset = 1'b1;
    drive(idle);
    repeat (2) @(posedge Clk);
    #1 chk_zero("por");
    Reset = 1'b0;

    // Read granted, then reset lands before the completing edge
    drive(crd10);
    @(negedge Clk);
    chk("rst c_gnt", 32'(c_gnt), 1);
    chk("rst D_addr", 32'(D_addr), 32'h10);
    #2 Reset = 1'b1;
    #1 chk_zero("mid");
    @(posedge Clk);
    #1 chk("rst no rvalid", 32'(c_rvalid), 0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("post c_gnt", 32'(c_gnt), 1);
    chk("post c_rvalid", 32'(c_rvalid), 0);
    @(posedge Clk);
    #1 drive(idle);
    @(negedge Clk);
    chk("post rvalid", 32'(c_rvalid), 1);
    chk("post rdata", 32'(rdata), 32'h1010);

    for (int i = 0; i < NV; i++) begin
      @(posedge Clk);
      #1 drive(vt[i]);
      @(negedge Clk);
      s = $sformatf("v%0d", i);
      chk({s, " c_gnt"}, 32'(c_gnt), 32'(vt[i].gc));
      chk({s, " d_gnt"}, 32'(d_gnt), 32'(vt[i].gd));
      chk({s, " D_wr"}, 32'(D_wr), 32'(vt[i].wr));
      chk({s, " D_addr"}, 32'(D_addr), 32'(vt[i].ad));
      chk({s, " D_wdata"}, 32'(D_wdata), 32'(vt[i].wd));
      chk({s, " c_rvalid"}, 32'(c_rvalid), 32'(vt[i].crv));
      chk({s, " d_rvalid"}, 32'(d_rvalid), 32'(vt[i].drv));
      chk({s, " d_starved"}, 32'(d_starved), 32'(vt[i].st));
      if (vt[i].crv || vt[i].drv)
        chk({s, " rdata"}, 32'(rdata), 32'(vt[i].rd));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
